// File: rtl/mult_pkg.sv
// Shared types and constants for the iterative HI/LO multiplier.
// The stall logic uses MULT_LATENCY to size its MFHI/MFLO hazard window.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mult_state_e;

  localparam int MULT_WIDTH   = 32;
  localparam int MULT_LATENCY = MULT_WIDTH + 1;

  function automatic int mult_latency(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/mult_unit_if.sv
// Execute-stage multiply request/result bundle.
// The datapath drives it through the master modport; mult_unit takes the slave modport.
interface mult_unit_if #(
  parameter int WIDTH = 32
);
  import mult_pkg::*;

  logic             start_mult;
  logic             mult_sign;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output start_mult, mult_sign, src_a, src_b,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start_mult, mult_sign, src_a, src_b,
    output hi, lo, busy, done
  );

endinterface

// File: rtl/mult_unit.sv
// Radix-2 shift-add multiplier producing the 2*WIDTH-bit HI/LO product.
// Signed operands run as magnitudes; the sign is restored in a final FIX cycle.
module mult_unit
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic       clk,
  input  logic       reset,
  mult_unit_if.slave bus
);

  localparam int                CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  mult_state_e        state;
  logic [WIDTH:0]     mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic               neg;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               busy_r;
  logic               done_r;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] result;

  // Magnitudes are unsigned WIDTH-bit, so the most negative operand maps cleanly onto 2^(WIDTH-1).
  always_comb begin
    a_mag    = (bus.mult_sign && bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
    b_mag    = (bus.mult_sign && bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;
    addend   = mplier[0] ? mcand : '0;
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + addend;
    acc_next = {sum, acc[WIDTH-1:1]};
    result   = neg ? -acc : acc;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_mult) begin
            mcand  <= {1'b0, a_mag};
            mplier <= b_mag;
            neg    <= bus.mult_sign & (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            state <= FIX;
          end
        end
        FIX: begin
          {hi_r, lo_r} <= result;
          done_r       <= 1'b1;
          busy_r       <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: vector table plus back-to-back, ignored-start and reset-abort sequences.
module tb_mult_unit;
  import mult_pkg::*;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           sgn;
    logic [2*W-1:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];
  logic [2*W-1:0] sb_q[$];

  mult_unit_if #(.WIDTH(W)) bus ();

  mult_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    logic signed [2*W-1:0] sa;
    logic signed [2*W-1:0] sb;
    if (sgn) begin
      sa = {{W{a[W-1]}}, a};
      sb = {{W{b[W-1]}}, b};
      return sa * sb;
    end
    return {{W{1'b0}}, a} * {{W{1'b0}}, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after an edge; the next edge samples the request, then operands are scrambled.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                          input logic [2*W-1:0] exp);
    bus.start_mult = 1'b1;
    bus.src_a      = a;
    bus.src_b      = b;
    bus.mult_sign  = sgn;
    sb_q.push_back(exp);
    tick();
    bus.start_mult = 1'b0;
    bus.src_a      = $urandom;
    bus.src_b      = $urandom;
    bus.mult_sign  = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= LAT + 8; i++) begin
      tick();
      if (bus.done === 1'b1) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic finish_op(input string name, input int n);
    logic [2*W-1:0] exp;
    chk({name, "_latency"}, 64'(n), 64'(LAT));
    chk({name, "_busy_in_done"}, 64'(bus.busy), 64'd0);
    checks++;
    if (n > 0 && sb_q.size() > 0) begin
      checks--;
      exp = sb_q.pop_front();
      chk(name, {bus.hi, bus.lo}, exp);
    end else begin
      errors++;
      $display("FAIL %s no_result scoreboard_depth=%0d done_edge=%0d", name, sb_q.size(), n);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end
  endtask

  initial begin
    int             n;
    logic [W-1:0]   ra;
    logic [W-1:0]   rb;
    logic           rs;
    logic [2*W-1:0] held;

    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001});
    vecs.push_back('{32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB});
    vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000});
    vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000});
    vecs.push_back('{32'h0000_0000, 32'h1234_5678, 1'b1, 64'h0000_0000_0000_0000});
    vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_8000_0000});
    vecs.push_back('{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000});
    vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE});
    vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 64'h0000_0001_FFFF_FFFE});
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'(i % 2);
      vecs.push_back('{ra, rb, rs, model(ra, rb, rs)});
    end

    bus.start_mult = 1'b0;
    bus.mult_sign  = 1'b0;
    bus.src_a      = '0;
    bus.src_b      = '0;
    reset          = 1'b0;
    tick();
    tick();
    chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);

    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_outputs", {bus.hi, bus.lo, 1'b0, bus.busy, bus.done} >> 3, 64'd0);
      chk("idle_flags", {62'd0, bus.busy, bus.done}, 64'd0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].exp);
      chk("busy_after_start", 64'(bus.busy), 64'd1);
      wait_done(n);
      finish_op($sformatf("vec%0d", i), n);
      held = {bus.hi, bus.lo};
      for (int j = 0; j < 3; j++) begin
        tick();
        chk("done_single_pulse", 64'(bus.done), 64'd0);
        chk("hilo_hold", {bus.hi, bus.lo}, held);
      end
    end

    // Request while busy is dropped; a request in the done cycle is taken.
    start_op(32'd6, 32'd7, 1'b0, 64'd42);
    n = -1;
    for (int i = 1; i <= LAT + 8; i++) begin
      tick();
      if (i == 10) begin
        bus.start_mult = 1'b1;
        bus.src_a      = 32'd2;
        bus.src_b      = 32'd2;
      end else begin
        bus.start_mult = 1'b0;
      end
      if (bus.done === 1'b1) begin
        n = i;
        break;
      end
    end
    finish_op("busy_ignore", n);
    start_op(32'd5, 32'd5, 1'b1, 64'd25);
    wait_done(n);
    finish_op("back_to_back", n);

    // Reset in mid-operation must abort without a result.
    tick();
    bus.start_mult = 1'b1;
    bus.src_a      = 32'd100;
    bus.src_b      = 32'd100;
    bus.mult_sign  = 1'b0;
    tick();
    bus.start_mult = 1'b0;
    for (int i = 1; i < 15; i++) tick();
    reset = 1'b0;
    tick();
    chk("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    reset = 1'b1;
    n = 0;
    for (int i = 0; i < LAT + 8; i++) begin
      tick();
      if (bus.done === 1'b1) n++;
    end
    chk("abort_no_done", 64'(n), 64'd0);
    chk("abort_hilo_after", {bus.hi, bus.lo}, 64'd0);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
